// File: rtl/caprom_leaf_sequencer.sv
// caprom_leaf_sequencer: round-robin front end that fetches 128-bit leaves
// from the discovery ROM CSR window (INDEX write followed by four DATA reads)
// and returns each leaf to the requester that won arbitration.
module caprom_leaf_sequencer #(
   parameter int                NUM_REQ    = 2,
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter bit                SKIP_INDEX = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_leaf,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [127:0]           rsp_data,
   output logic                   rsp_fault,
   output logic                   csr_req_valid,
   input  logic                   csr_req_ready,
   output logic [ADDR_W-1:0]      csr_req_addr,
   output logic                   csr_req_write,
   output logic [31:0]            csr_req_wdata,
   input  logic                   csr_rsp_valid,
   output logic                   csr_rsp_ready,
   input  logic [31:0]            csr_rsp_rdata,
   input  logic                   csr_rsp_fault
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_IDX_REQ, S_IDX_RSP, S_DAT_REQ, S_DAT_RSP, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        w_q, w_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [31:0]       leaf_q, leaf_d;
   logic [31:0]       index_q, index_d;
   logic              index_valid_q, index_valid_d;
   logic [3:0][31:0]  data_q, data_d;
   logic              fault_q, fault_d;

   // Candidate order for the round-robin search starts just after the last winner.
   logic [IW-1:0]     cand_idx [NUM_REQ];
   logic [31:0]       leaf_arr [NUM_REQ];
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign cand_idx[gi] = IW'((int'(rr_q) + gi + 1) % NUM_REQ);
      assign leaf_arr[gi] = req_leaf[gi*32 +: 32];
   end

   logic              pick_found;
   logic [IW-1:0]     pick_idx;
   logic [31:0]       pick_leaf;

   // First valid requester in round-robin order.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req_valid[cand_idx[k]]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx[k];
         end
      end
      pick_leaf = leaf_arr[pick_idx];
   end

   // State and datapath registers; reset abandons any fetch in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         w_q           <= 2'd0;
         rr_q          <= IW'(NUM_REQ - 1);
         grant_q       <= '0;
         leaf_q        <= '0;
         index_q       <= '0;
         index_valid_q <= 1'b0;
         data_q        <= '0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         w_q           <= w_d;
         rr_q          <= rr_d;
         grant_q       <= grant_d;
         leaf_q        <= leaf_d;
         index_q       <= index_d;
         index_valid_q <= index_valid_d;
         data_q        <= data_d;
         fault_q       <= fault_d;
      end
   end

   // Next-state logic and all handshake outputs of the fetch sequence.
   always_comb begin
      state_d       = state_q;
      w_d           = w_q;
      rr_d          = rr_q;
      grant_d       = grant_q;
      leaf_d        = leaf_q;
      index_d       = index_q;
      index_valid_d = index_valid_q;
      data_d        = data_q;
      fault_d       = fault_q;
      req_ready     = '0;
      rsp_valid     = '0;
      csr_req_valid = 1'b0;
      csr_req_addr  = '0;
      csr_req_write = 1'b0;
      csr_req_wdata = '0;
      csr_rsp_ready = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Grant is gated by rst_n so every output reads zero during reset.
            if (pick_found && rst_n) begin
               req_ready[pick_idx] = 1'b1;
               leaf_d  = pick_leaf;
               grant_d = pick_idx;
               rr_d    = pick_idx;
               data_d  = '0;
               fault_d = 1'b0;
               w_d     = 2'd0;
               if (SKIP_INDEX && index_valid_q && (pick_leaf == index_q))
                  state_d = S_DAT_REQ;
               else
                  state_d = S_IDX_REQ;
            end
         end
         S_IDX_REQ: begin
            csr_req_valid = 1'b1;
            csr_req_addr  = BASE_ADDR;
            csr_req_write = 1'b1;
            csr_req_wdata = leaf_q;
            if (csr_req_ready) state_d = S_IDX_RSP;
         end
         S_IDX_RSP: begin
            csr_rsp_ready = 1'b1;
            if (csr_rsp_valid) begin
               if (csr_rsp_fault) begin
                  // The ROM's index is unknown after a failed write; skip reads.
                  index_valid_d = 1'b0;
                  fault_d       = 1'b1;
                  state_d       = S_DONE;
               end else begin
                  index_d       = leaf_q;
                  index_valid_d = 1'b1;
                  w_d           = 2'd0;
                  state_d       = S_DAT_REQ;
               end
            end
         end
         S_DAT_REQ: begin
            csr_req_valid = 1'b1;
            csr_req_addr  = BASE_ADDR + ADDR_W'(w_q) + ADDR_W'(1);
            if (csr_req_ready) state_d = S_DAT_RSP;
         end
         S_DAT_RSP: begin
            csr_rsp_ready = 1'b1;
            if (csr_rsp_valid) begin
               data_d[w_q] = csr_rsp_fault ? 32'd0 : csr_rsp_rdata;
               fault_d     = fault_q | csr_rsp_fault;
               if (w_q == 2'd3) begin
                  state_d = S_DONE;
               end else begin
                  w_d     = w_q + 2'd1;
                  state_d = S_DAT_REQ;
               end
            end
         end
         S_DONE: begin
            rsp_valid[grant_q] = 1'b1;
            if (rsp_ready[grant_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rsp_data  = data_q;
   assign rsp_fault = fault_q;

endmodule

// File: tb/tb_caprom_leaf_sequencer.sv
// Bench for caprom_leaf_sequencer: table-driven fetches against a small CSR
// slave model, plus hand-written fault, backpressure, reset and arbitration runs.
module tb_caprom_leaf_sequencer;
   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 32;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_leaf;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [127:0]          rsp_data;
   logic                  rsp_fault;
   logic                  csr_req_valid;
   logic                  csr_req_ready;
   logic [ADDR_W-1:0]     csr_req_addr;
   logic                  csr_req_write;
   logic [31:0]           csr_req_wdata;
   logic                  csr_rsp_valid;
   logic                  csr_rsp_ready;
   logic [31:0]           csr_rsp_rdata;
   logic                  csr_rsp_fault;

   always #5 clk = ~clk;

   caprom_leaf_sequencer #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .BASE_ADDR('0), .SKIP_INDEX(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_leaf(req_leaf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
      .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready), .csr_req_addr(csr_req_addr),
      .csr_req_write(csr_req_write), .csr_req_wdata(csr_req_wdata),
      .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
      .csr_rsp_rdata(csr_rsp_rdata), .csr_rsp_fault(csr_rsp_fault)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] oh(input int i);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // ---------------- CSR slave model ----------------
   logic [3:0][31:0] rd_words;
   int               fault_off = -1;   // 0 = INDEX write, 1..4 = DATA0..3
   int               stall_off = -1;
   int               stall_n   = 0;
   logic             s_pending;
   logic             smp_req_valid, smp_rsp_ready, prev_stall;
   logic [31:0]      smp_addr, smp_wdata;
   logic             smp_write;
   logic [31:0]      log_addr [16];
   logic             log_wr   [16];
   logic [31:0]      log_wd   [16];
   int               log_n = 0;

   // Inputs are decided at the falling edge from what the DUT presents; a
   // handshake is recognised one falling edge after the rising edge it completed on.
   initial begin
      csr_req_ready = 1'b0; csr_rsp_valid = 1'b0; csr_rsp_rdata = '0; csr_rsp_fault = 1'b0;
      s_pending = 1'b0; smp_req_valid = 1'b0; smp_rsp_ready = 1'b0; prev_stall = 1'b0;
      smp_addr = '0; smp_wdata = '0; smp_write = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            csr_req_ready = 1'b0; csr_rsp_valid = 1'b0; csr_rsp_rdata = '0; csr_rsp_fault = 1'b0;
            s_pending = 1'b0; smp_req_valid = 1'b0; smp_rsp_ready = 1'b0; prev_stall = 1'b0;
         end else begin
            if (csr_rsp_valid && smp_rsp_ready) begin
               csr_rsp_valid = 1'b0; csr_rsp_fault = 1'b0; csr_rsp_rdata = '0;
               s_pending = 1'b0;
            end
            if (csr_req_ready && smp_req_valid) begin
               int off;
               off = int'(smp_addr);
               if (log_n < 16) begin
                  log_addr[log_n] = smp_addr; log_wr[log_n] = smp_write; log_wd[log_n] = smp_wdata;
               end
               log_n++;
               s_pending     = 1'b1;
               csr_rsp_valid = 1'b1;
               csr_rsp_fault = (off == fault_off);
               if (smp_write || off < 1 || off > 4) csr_rsp_rdata = '0;
               else if (off == fault_off)          csr_rsp_rdata = 32'hDEAD_BEEF;
               else                                csr_rsp_rdata = rd_words[off-1];
            end
            if (prev_stall)
               check("csr_hold_stable", {csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata},
                     {1'b1, smp_write, smp_addr, smp_wdata});
            if (s_pending)
               check("single_outstanding", 128'(csr_req_valid), 128'(0));
            if (csr_req_valid && !s_pending) begin
               if (stall_n > 0 && int'(csr_req_addr) == stall_off) begin
                  csr_req_ready = 1'b0;
                  stall_n--;
               end else begin
                  csr_req_ready = 1'b1;
               end
            end else begin
               csr_req_ready = 1'b0;
            end
            prev_stall    = csr_req_valid && !csr_req_ready;
            smp_req_valid = csr_req_valid;
            smp_rsp_ready = csr_rsp_ready;
            smp_addr      = csr_req_addr;
            smp_write     = csr_req_write;
            smp_wdata     = csr_req_wdata;
         end
      end
   end

   // ---------------- one complete fetch ----------------
   task automatic run_fetch(input string name, input int id, input logic [31:0] leaf, input bit keep,
                            input logic [127:0] exp_data, input bit exp_fault, input int exp_lat,
                            input bit exp_wr, input int exp_nrd, input int hold);
      int n;
      int lat;
      int j;
      bit busy_grant;
      bit stable;
      bit seq_ok;
      logic [127:0] snap;
      if (!keep) begin
         @(negedge clk);
         req_valid[id] = 1'b1;
         req_leaf[id*32 +: 32] = leaf;
      end
      #1;
      n = 0;
      while (req_ready == '0 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check({name, "_grant"}, 128'(req_ready), 128'(oh(id)));
      log_n = 0;
      lat = 0;
      busy_grant = 1'b0;
      do begin
         @(negedge clk); #1;
         lat++;
         if (lat == 1 && !keep) req_valid[id] = 1'b0;
         if (req_ready != '0) busy_grant = 1'b1;
      end while (rsp_valid == '0 && lat < 60);
      check({name, "_rsp_valid"}, 128'(rsp_valid), 128'(oh(id)));
      check({name, "_latency"}, 128'(lat), 128'(exp_lat));
      check({name, "_data"}, rsp_data, exp_data);
      check({name, "_fault"}, 128'(rsp_fault), 128'(exp_fault));
      seq_ok = (log_n == (exp_wr ? 1 : 0) + exp_nrd);
      j = 0;
      if (seq_ok && exp_wr) begin
         if (log_addr[0] !== 32'd0 || log_wr[0] !== 1'b1 || log_wd[0] !== leaf) seq_ok = 1'b0;
         j = 1;
      end
      for (int r = 0; r < exp_nrd && seq_ok; r++)
         if (log_addr[j+r] !== 32'(r + 1) || log_wr[j+r] !== 1'b0 || log_wd[j+r] !== 32'd0) seq_ok = 1'b0;
      check({name, "_csr_sequence"}, 128'(seq_ok), 128'(1));
      snap   = rsp_data;
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         rsp_ready = ~oh(id);
         @(negedge clk); #1;
         if (rsp_valid !== oh(id) || rsp_data !== snap || rsp_fault !== exp_fault) stable = 1'b0;
         if (req_ready != '0) busy_grant = 1'b1;
      end
      if (hold > 0) check({name, "_rsp_stable"}, 128'(stable), 128'(1));
      check({name, "_no_grant_busy"}, 128'(busy_grant), 128'(0));
      rsp_ready = oh(id);
      @(negedge clk);
      rsp_ready = '0;
      #1;
      check({name, "_rsp_drop"}, 128'(rsp_valid), 128'(0));
      $display("fetch %s: req%0d leaf=%h data=%h fault=%0d latency=%0d csr_txns=%0d",
               name, id, leaf, rsp_data, exp_fault, lat, log_n);
   endtask

   typedef struct {
      int           id;
      logic [31:0]  leaf;
      logic [127:0] rd;
      int           lat;
      bit           wr;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{0, 32'h0000_0001, 128'h00000044_00000033_00000022_00000011, 11, 1'b1};
      vecs[1] = '{1, 32'h0000_0001, 128'h0A0B0C0D_01020304_FFFFFFFF_80000000,  9, 1'b0};
      vecs[2] = '{0, 32'h0000_0002, 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0, 11, 1'b1};
      vecs[3] = '{1, 32'h0000_0002, 128'hCAFEF00D_00000001_00000000_7FFFFFFF,  9, 1'b0};
      vecs[4] = '{0, 32'hFFFF_FFFF, 128'h55555555_AAAAAAAA_00C0FFEE_DEADC0DE, 11, 1'b1};

      rst_n = 1'b0; req_valid = '0; req_leaf = '0; rsp_ready = '0; rd_words = '0;
      repeat (2) @(negedge clk);
      req_valid = 2'b11;
      #1;
      check("reset_req_ready", 128'(req_ready), 128'(0));
      check("reset_csr", {csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata, csr_rsp_ready},
            128'(0));
      check("reset_rsp", {rsp_valid, rsp_fault, rsp_data}, 131'(0) > 0 ? 128'(1) : 128'(0));
      check("reset_rsp_data", rsp_data, 128'(0));
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Table: plain fetches, index skip, and re-write on a new leaf.
      for (int v = 0; v < 5; v++) begin
         rd_words = vecs[v].rd;
         run_fetch($sformatf("vec%0d", v), vecs[v].id, vecs[v].leaf, 1'b0, vecs[v].rd, 1'b0,
                   vecs[v].lat, vecs[v].wr, 4, 0);
      end

      // Faulted INDEX write: no reads, zero data, and the cached index is forgotten.
      rd_words  = 128'h99999999_88888888_77777777_66666666;
      fault_off = 0;
      run_fetch("idx_fault", 0, 32'h0000_0008, 1'b0, 128'(0), 1'b1, 3, 1'b1, 0, 0);
      fault_off = -1;
      run_fetch("after_fault_old_leaf", 1, 32'hFFFF_FFFF, 1'b0, rd_words, 1'b0, 11, 1'b1, 4, 0);
      fault_off = 0;
      run_fetch("idx_fault2", 1, 32'h0000_0009, 1'b0, 128'(0), 1'b1, 3, 1'b1, 0, 0);
      fault_off = -1;
      run_fetch("after_fault_same_leaf", 0, 32'h0000_0009, 1'b0, rd_words, 1'b0, 11, 1'b1, 4, 0);
      run_fetch("skip_restored", 1, 32'h0000_0009, 1'b0, rd_words, 1'b0, 9, 1'b0, 4, 0);

      // DATA2 faults, DATA1 request stalled 3 cycles, response held 5 cycles.
      rd_words  = 128'h44444444_33333333_22222222_11111111;
      fault_off = 3;
      stall_off = 2;
      stall_n   = 3;
      run_fetch("data_fault_bp", 0, 32'h0000_00A5, 1'b0,
                128'h44444444_00000000_22222222_11111111, 1'b1, 14, 1'b1, 4, 5);
      fault_off = -1;
      stall_off = -1;
      run_fetch("data_fault_keeps_index", 1, 32'h0000_00A5, 1'b0, rd_words, 1'b0, 9, 1'b0, 4, 0);

      // Reset while waiting on the DATA1 response.
      rd_words = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_leaf[31:0] = 32'h0000_0033;
      #1;
      check("mid_grant", 128'(req_ready), 128'(oh(0)));
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk); #1;
         if (c == 1) req_valid[0] = 1'b0;
      end
      check("mid_in_dat_rsp", 128'(csr_rsp_ready), 128'(1));
      check("mid_word0_loaded", 128'(rsp_data[31:0]), 128'(32'h0A0A0A0A));
      rst_n = 1'b0;
      #1;
      check("mid_rst_csr_req", {csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata}, 128'(0));
      check("mid_rst_csr_rsp_ready", 128'(csr_rsp_ready), 128'(0));
      check("mid_rst_rsp", {rsp_valid, rsp_fault, req_ready}, 128'(0));
      check("mid_rst_rsp_data", rsp_data, 128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Both requesters held high: grants alternate 0,1,0,1 and the first
      // fetch of leaf 0x33 after reset writes INDEX again.
      req_leaf[31:0]  = 32'h0000_0033;
      req_leaf[63:32] = 32'h0000_0044;
      req_valid       = 2'b11;
      for (int g = 0; g < 4; g++)
         run_fetch($sformatf("rr%0d", g), g % 2, (g % 2 == 0) ? 32'h33 : 32'h44, 1'b1,
                   rd_words, 1'b0, 11, 1'b1, 4, 0);
      req_valid = '0;

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
